// File: rtl/cpu_pkg.sv
// cpu_pkg: types shared by the CPU controller and the ALU.
//   opcode_e : 3-bit instruction opcode as held in the instruction register.
//   state_e  : controller sequencing state; the eight phases occupy 0..7,
//              HALTED sits above them so it cannot alias a phase.
//   is_aluop : opcodes that read an operand into the accumulator.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    ST_INST_ADDR  = 4'd0,
    ST_INST_FETCH = 4'd1,
    ST_INST_LOAD  = 4'd2,
    ST_IDLE       = 4'd3,
    ST_OP_ADDR    = 4'd4,
    ST_OP_FETCH   = 4'd5,
    ST_ALU_OP     = 4'd6,
    ST_STORE      = 4'd7,
    ST_HALTED     = 4'd8
  } state_e;

  // Phase number reported while halted (the phase in which HLT was decoded).
  localparam logic [2:0] HALTED_PHASE = 3'd4;

  function automatic logic is_aluop(input opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/controller.sv
// controller: eight-phase instruction sequencer for the simple CPU.
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset (returns to INST_ADDR)
//   opcode[2:0]    opcode from the instruction register
//   zero           accumulator-is-zero flag
//   sel            address mux select (1 = PC, 0 = IR operand)
//   rd, wr         memory read enable / write strobe
//   ld_ir, ld_ac, ld_pc, inc_pc   register load / increment controls
//   data_e         accumulator bus driver enable
//   halt           processor halted
//   phase[2:0]     current phase (reads 4 while halted)
// Outputs are decoded combinationally from the state register, opcode and
// zero, so opcode/zero only ever influence the phase they are observed in.
module controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       halt,
  output logic       inc_pc,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       wr,
  output logic       data_e,
  output logic [2:0] phase
);

  state_e  state_q, state_d;
  state_e  dec_state;
  opcode_e op;
  logic    aluop;
  logic [3:0] dec_bits;

  assign op    = opcode_e'(opcode);
  assign aluop = is_aluop(op);

  // Next-state: a fixed ring of eight phases; HLT decoded in OP_ADDR exits
  // the ring into HALTED, which only reset leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INST_ADDR:  state_d = ST_INST_FETCH;
      ST_INST_FETCH: state_d = ST_INST_LOAD;
      ST_INST_LOAD:  state_d = ST_IDLE;
      ST_IDLE:       state_d = ST_OP_ADDR;
      ST_OP_ADDR:    state_d = (op == OP_HLT) ? ST_HALTED : ST_OP_FETCH;
      ST_OP_FETCH:   state_d = ST_ALU_OP;
      ST_ALU_OP:     state_d = ST_STORE;
      ST_STORE:      state_d = ST_INST_ADDR;
      ST_HALTED:     state_d = ST_HALTED;
      default:       state_d = ST_INST_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INST_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  // While rst is held the outputs already show INST_ADDR, so nothing from a
  // half-finished instruction (e.g. a STO write) leaks out before the edge.
  assign dec_state = rst ? ST_INST_ADDR : state_q;
  assign dec_bits  = dec_state;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    phase  = dec_bits[2:0];
    case (dec_state)
      ST_INST_ADDR: begin
        sel = 1'b1;
      end
      ST_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      ST_INST_LOAD, ST_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      ST_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (op == OP_HLT);
      end
      ST_OP_FETCH: begin
        rd = aluop;
      end
      ST_ALU_OP: begin
        rd     = aluop;
        inc_pc = (op == OP_SKZ) && zero;
        ld_pc  = (op == OP_JMP);
        data_e = (op == OP_STO);
      end
      ST_STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        wr     = (op == OP_STO);
        ld_pc  = (op == OP_JMP);
        data_e = (op == OP_STO);
      end
      ST_HALTED: begin
        halt  = 1'b1;
        phase = HALTED_PHASE;
      end
      default: begin
        sel = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// Bench for controller: a phase/halt model advanced once per clock plus an
// output table derived from the per-phase rules, driven by directed and
// $urandom stimulus.
module tb_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
  logic [2:0] phase;
  logic [11:0] obs;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_phase = 0;
  bit m_halt  = 1'b0;

  controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
    .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e), .phase(phase)
  );

  always #5 clk = ~clk;

  assign obs = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, phase};

  // Expected {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e,phase[2:0]}
  function automatic logic [11:0] exp_out(input bit r, input int ph_in, input bit h_in,
                                          input logic [2:0] op, input bit z);
    int ph;
    bit h, alu;
    logic [11:0] e;
    ph  = r ? 0 : ph_in;
    h   = r ? 1'b0 : h_in;
    alu = (op >= 3'd2) && (op <= 3'd5);
    if (h) return {3'b000, 1'b1, 5'b00000, 3'd4};
    e[11]  = (ph <= 3);
    e[10]  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    e[9]   = (ph == 2 || ph == 3);
    e[8]   = (ph == 4 && op == 3'd0);
    e[7]   = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    e[6]   = (ph == 7 && alu);
    e[5]   = (ph >= 6 && op == 3'd7);
    e[4]   = (ph == 7 && op == 3'd6);
    e[3]   = (ph >= 6 && op == 3'd6);
    e[2:0] = ph[2:0];
    return e;
  endfunction

  // One rising edge; the model follows the inputs held across that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      m_halt  = 1'b0;
    end else if (!m_halt) begin
      if (m_phase == 4 && opcode == 3'd0) m_halt = 1'b1;
      else m_phase = (m_phase + 1) % 8;
    end
    #1;
  endtask

  // Reset for one edge and release: leaves the DUT in phase 0, rst low.
  task automatic restart();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      rst = 1'b1; opcode = 3'($urandom_range(0, 7)); zero = 1'($urandom);
      #1;
      n_vec++;
      if (obs !== exp_out(rst, m_phase, m_halt, opcode, zero)) begin
        n_err++;
        $display("FAIL reset c%0d: got %03h want %03h", c, obs, exp_out(rst, m_phase, m_halt, opcode, zero));
      end
      n_vec++;
      if (phase !== 3'd0 || sel !== 1'b1 || halt !== 1'b0) begin
        n_err++;
        $display("FAIL reset_vals c%0d: got phase=%0d sel=%0b halt=%0b want 0 1 0", c, phase, sel, halt);
      end
      tick();
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_add();
    restart();
    opcode = 3'd2; zero = 1'b0;
    for (int c = 0; c < 9; c++) begin
      #1;
      n_vec++;
      if (obs !== exp_out(rst, m_phase, m_halt, opcode, zero)) begin
        n_err++;
        $display("FAIL add c%0d: got %03h want %03h", c, obs, exp_out(rst, m_phase, m_halt, opcode, zero));
      end
      n_vec++;
      if (phase !== 3'(c % 8) || ld_ac !== (c == 7) || inc_pc !== (c == 4)) begin
        n_err++;
        $display("FAIL add_seq c%0d: got phase=%0d ld_ac=%0b inc_pc=%0b want phase=%0d", c, phase, ld_ac, inc_pc, c % 8);
      end
      tick();
    end
  endtask

  task automatic test_sto();
    restart();
    opcode = 3'd6;
    for (int c = 0; c < 8; c++) begin
      zero = 1'($urandom);
      #1;
      n_vec++;
      if (obs !== exp_out(rst, m_phase, m_halt, opcode, zero)) begin
        n_err++;
        $display("FAIL sto c%0d: got %03h want %03h", c, obs, exp_out(rst, m_phase, m_halt, opcode, zero));
      end
      n_vec++;
      if (wr !== (c == 7) || data_e !== (c >= 6) || (c >= 5 && rd !== 1'b0)) begin
        n_err++;
        $display("FAIL sto_ctl c%0d: got wr=%0b data_e=%0b rd=%0b", c, wr, data_e, rd);
      end
      tick();
    end
  endtask

  task automatic test_skz();
    for (int z = 1; z >= 0; z--) begin
      restart();
      opcode = 3'd1; zero = 1'(z);
      for (int c = 0; c < 8; c++) begin
        #1;
        n_vec++;
        if (obs !== exp_out(rst, m_phase, m_halt, opcode, zero)) begin
          n_err++;
          $display("FAIL skz z%0d c%0d: got %03h want %03h", z, c, obs, exp_out(rst, m_phase, m_halt, opcode, zero));
        end
        n_vec++;
        if (inc_pc !== (c == 4 || (z == 1 && c == 6))) begin
          n_err++;
          $display("FAIL skz_inc z%0d c%0d: got inc_pc=%0b", z, c, inc_pc);
        end
        tick();
      end
    end
  endtask

  task automatic test_jmp();
    restart();
    opcode = 3'd7;
    for (int c = 0; c < 8; c++) begin
      zero = 1'($urandom);
      #1;
      n_vec++;
      if (obs !== exp_out(rst, m_phase, m_halt, opcode, zero)) begin
        n_err++;
        $display("FAIL jmp c%0d: got %03h want %03h", c, obs, exp_out(rst, m_phase, m_halt, opcode, zero));
      end
      n_vec++;
      if (ld_pc !== (c >= 6) || ld_ac !== 1'b0 || wr !== 1'b0) begin
        n_err++;
        $display("FAIL jmp_ctl c%0d: got ld_pc=%0b ld_ac=%0b wr=%0b", c, ld_pc, ld_ac, wr);
      end
      tick();
    end
  endtask

  task automatic test_hlt();
    restart();
    opcode = 3'd2; zero = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    opcode = 3'd0;
    #1;
    n_vec++;
    if (phase !== 3'd4 || halt !== 1'b1 || inc_pc !== 1'b1) begin
      n_err++;
      $display("FAIL hlt_decode: got phase=%0d halt=%0b inc_pc=%0b want 4 1 1", phase, halt, inc_pc);
    end
    tick();
    for (int c = 0; c < 24; c++) begin
      opcode = 3'(c % 8); zero = 1'($urandom);
      #1;
      n_vec++;
      if (obs !== exp_out(rst, m_phase, m_halt, opcode, zero) || halt !== 1'b1 || phase !== 3'd4) begin
        n_err++;
        $display("FAIL halted c%0d: got %03h want %03h", c, obs, exp_out(rst, m_phase, m_halt, opcode, zero));
      end
      tick();
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (phase !== 3'd0 || halt !== 1'b0) begin
      n_err++;
      $display("FAIL hlt_rst: got phase=%0d halt=%0b want 0 0", phase, halt);
    end
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (phase !== 3'd1 || halt !== 1'b0) begin
      n_err++;
      $display("FAIL hlt_resume: got phase=%0d halt=%0b want 1 0", phase, halt);
    end
  endtask

  task automatic test_reset_mid();
    bit wr_seen;
    wr_seen = 1'b0;
    restart();
    opcode = 3'd6; zero = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      wr_seen |= wr;
      tick();
    end
    rst = 1'b1;
    #1;
    wr_seen |= wr;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      wr_seen |= wr;
      n_vec++;
      if (phase !== 3'(c) || wr_seen !== 1'b0) begin
        n_err++;
        $display("FAIL rst_at_alu c%0d: got phase=%0d wr_seen=%0b want phase=%0d wr_seen=0", c, phase, wr_seen, c);
      end
      tick();
    end
    // reset coincident with HLT decode must win
    restart();
    opcode = 3'd2;
    for (int c = 0; c < 4; c++) tick();
    opcode = 3'd0; rst = 1'b1;
    tick();
    rst = 1'b0; opcode = 3'd2;
    #1;
    n_vec++;
    if (phase !== 3'd0 || halt !== 1'b0) begin
      n_err++;
      $display("FAIL rst_vs_hlt: got phase=%0d halt=%0b want 0 0", phase, halt);
    end
    tick();
    n_vec++;
    if (phase !== 3'd1 || halt !== 1'b0) begin
      n_err++;
      $display("FAIL rst_vs_hlt_next: got phase=%0d halt=%0b want 1 0", phase, halt);
    end
  endtask

  task automatic test_random();
    restart();
    for (int c = 0; c < 600; c++) begin
      rst    = ($urandom_range(0, 24) == 0);
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom);
      #1;
      n_vec++;
      if (obs !== exp_out(rst, m_phase, m_halt, opcode, zero)) begin
        n_err++;
        $display("FAIL random c%0d: rst=%0b op=%0d z=%0b got %03h want %03h",
                 c, rst, opcode, zero, obs, exp_out(rst, m_phase, m_halt, opcode, zero));
      end
      // mid-phase input change must only move this phase's outputs
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom);
      #1;
      n_vec++;
      if (obs !== exp_out(rst, m_phase, m_halt, opcode, zero)) begin
        n_err++;
        $display("FAIL random_mid c%0d: op=%0d z=%0b got %03h want %03h",
                 c, opcode, zero, obs, exp_out(rst, m_phase, m_halt, opcode, zero));
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; opcode = 3'd0; zero = 1'b0;
    test_reset();
    test_add();
    test_sto();
    test_skz();
    test_jmp();
    test_hlt();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
